// File: rtl/lock_reset_sequencer.sv
// Staged reset release gated on a qualified PLL lock. A relock request is raised when lock
// stays absent too long, and lock losses after release are counted (saturating).
module lock_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int RELOCK_TIMEOUT     = 65536,
  parameter int RELOCK_PULSE       = 16,
  parameter int CNT_W              = 8
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             sys_rst_n,
  output logic             dsp_rst_n,
  output logic             ready,
  output logic             relock_req,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       state_o
);

  localparam int MAX_AB = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_CD = (RELOCK_TIMEOUT > RELOCK_PULSE) ? RELOCK_TIMEOUT : RELOCK_PULSE;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP + 1);

  localparam logic [CW-1:0] QUAL_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(RELOCK_PULSE - 1);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_QUAL   = 3'd1,
    ST_STAGE  = 3'd2,
    ST_RUN    = 3'd3,
    ST_RELOCK = 3'd4
  } state_t;

  typedef struct packed {
    logic sys;
    logic dsp;
    logic rdy;
    logic rlk;
  } out_t;

  function automatic out_t decode(input state_t s);
    out_t o;
    o.sys = (s == ST_STAGE) || (s == ST_RUN);
    o.dsp = (s == ST_RUN);
    o.rdy = (s == ST_RUN);
    o.rlk = (s == ST_RELOCK);
    return o;
  endfunction

  logic          sync_q, lock_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          loss;
  out_t          out_d;

  // pll_locked crosses domains here and nowhere else
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= pll_locked;
      lock_s <= sync_q;
    end
  end

  always_comb begin
    state_d = state_q;
    loss    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (lock_s)                  state_d = ST_QUAL;
        else if (cnt_q == WAIT_LAST) state_d = ST_RELOCK;
      end
      ST_QUAL: begin
        if (!lock_s)                 state_d = ST_WAIT;
        else if (cnt_q == QUAL_LAST) state_d = ST_STAGE;
      end
      ST_STAGE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          loss    = 1'b1;
        end else if (cnt_q == STAGE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          loss    = 1'b1;
        end
      end
      ST_RELOCK: begin
        if (cnt_q == PULSE_LAST) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // RUN has no timed exit, so the counter is parked there instead of wrapping
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q || state_q == ST_RUN) cnt_d = '0;
  end

  assign out_d = decode(state_d);

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT;
      cnt_q         <= '0;
      sys_rst_n     <= 1'b0;
      dsp_rst_n     <= 1'b0;
      ready         <= 1'b0;
      relock_req    <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sys_rst_n  <= out_d.sys;
      dsp_rst_n  <= out_d.dsp;
      ready      <= out_d.rdy;
      relock_req <= out_d.rlk;
      if (loss && lock_loss_cnt != {CNT_W{1'b1}})
        lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_lock_reset_sequencer.sv
// Scoreboarded random bench for lock_reset_sequencer: a cycle-level behavioural model queues
// expected outputs, and a negedge monitor pops them and compares against the DUT.
module tb_lock_reset_sequencer;
  localparam int LS = 8, SG = 4, TO = 32, RP = 4, CW = 2;

  typedef struct packed {
    logic          sys;
    logic          dsp;
    logic          rdy;
    logic          rlk;
    logic [CW-1:0] cnt;
    logic [2:0]    st;
  } obs_t;

  logic          clk_100MHz = 1'b0;
  logic          rst_n, pll_locked;
  logic          sys_rst_n, dsp_rst_n, ready, relock_req;
  logic [CW-1:0] lock_loss_cnt;
  logic [2:0]    state_o;

  lock_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LS), .STAGE_GAP(SG), .RELOCK_TIMEOUT(TO),
    .RELOCK_PULSE(RP), .CNT_W(CW)
  ) dut (
    .clk_100MHz(clk_100MHz), .rst_n(rst_n), .pll_locked(pll_locked),
    .sys_rst_n(sys_rst_n), .dsp_rst_n(dsp_rst_n), .ready(ready),
    .relock_req(relock_req), .lock_loss_cnt(lock_loss_cnt), .state_o(state_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int   vecs = 0, errs = 0;
  obs_t q[$];

  function automatic obs_t cur();
    return '{sys_rst_n, dsp_rst_n, ready, relock_req, lock_loss_cnt, state_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural reference: lock seen two samples late; phase dwell counted in whole cycles.
  // Phase numbers: 0 wait, 1 qualify, 2 staged, 3 running, 4 relock pulse.
  int m_s1, m_s2, m_ph, m_age, m_loss;

  function automatic obs_t m_obs();
    obs_t o;
    o.sys = (m_ph == 2) || (m_ph == 3);
    o.dsp = (m_ph == 3);
    o.rdy = (m_ph == 3);
    o.rlk = (m_ph == 4);
    o.cnt = CW'(m_loss);
    o.st  = 3'(m_ph);
    return o;
  endfunction

  task automatic enter(input int ph);
    m_ph  = ph;
    m_age = 0;
  endtask

  task automatic model_edge(input logic p);
    int lk;
    int done;
    lk   = m_s2;
    m_s2 = m_s1;
    m_s1 = int'(p);
    done = m_age + 1;  // cycles spent in current phase including this one
    case (m_ph)
      0: if (lk != 0) enter(1); else if (done == TO) enter(4); else m_age++;
      1: if (lk == 0) enter(0); else if (done == LS) enter(2); else m_age++;
      2, 3: begin
        if (lk == 0) begin
          m_loss = (m_loss + 1 > 3) ? 3 : m_loss + 1;
          enter(0);
        end else if (m_ph == 2 && done == SG) enter(3);
        else m_age++;
      end
      default: if (done == RP) enter(0); else m_age++;
    endcase
  endtask

  task automatic step(input logic p);
    pll_locked = p;
    @(posedge clk_100MHz);
    model_edge(p);
    q.push_back(m_obs());
    #1;
  endtask

  task automatic apply_reset(input bit mid);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(cur()), 32'd0);
    q.delete();
    if (mid) q.push_back('0);
    repeat (2) begin
      @(posedge clk_100MHz);
      q.push_back('0);
    end
    #1;
    m_s1 = 0; m_s2 = 0; m_ph = 0; m_age = 0; m_loss = 0;
    rst_n = 1'b1;
  endtask

  always @(negedge clk_100MHz) begin
    if (q.size() > 0) begin
      obs_t e, a;
      e = q.pop_front();
      a = cur();
      vecs++;
      if (a !== e) begin
        errs++;
        $display("FAIL scoreboard t=%0t actual sys=%b dsp=%b rdy=%b rlk=%b cnt=%0d st=%0d required sys=%b dsp=%b rdy=%b rlk=%b cnt=%0d st=%0d",
                 $time, a.sys, a.dsp, a.rdy, a.rlk, a.cnt, a.st, e.sys, e.dsp, e.rdy, e.rlk, e.cnt, e.st);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    pll_locked = 1'b0;
    #1;
    apply_reset(0);

    // lock from release: sys at 11, dsp/ready at 15
    for (int n = 1; n <= 16; n++) begin
      step(1);
      if (n == 10) chk("sys_before_11", 32'(sys_rst_n), 0);
      if (n == 11) chk("sys_at_11", 32'(sys_rst_n), 1);
      if (n == 14) chk("dsp_before_15", 32'(dsp_rst_n), 0);
      if (n == 15) chk("run_at_15", {29'd0, dsp_rst_n, ready, 1'b0} | 32'(state_o), 32'h7);
    end

    // lock loss in RUN, then re-sequence
    for (int n = 1; n <= 3; n++) begin
      step(0);
      if (n == 2) chk("loss_not_yet", 32'(sys_rst_n), 1);
      if (n == 3) chk("loss_outputs", {sys_rst_n, dsp_rst_n, ready, 1'b0, lock_loss_cnt, state_o}, 32'h8);
    end
    for (int n = 1; n <= 15; n++) begin
      step(1);
      if (n == 11) chk("reseq_sys", 32'(sys_rst_n), 1);
      if (n == 15) chk("reseq_dsp", 32'(dsp_rst_n), 1);
    end

    // glitch during qualification restarts it without counting a loss
    apply_reset(1);
    repeat (5) step(1);
    chk("in_qual", 32'(state_o), 1);
    repeat (5) step(0);
    chk("glitch_wait", {lock_loss_cnt, state_o}, 32'd0);
    for (int n = 1; n <= 12; n++) begin
      step(1);
      if (n == 10) chk("requal_sys_10", 32'(sys_rst_n), 0);
      if (n == 11) chk("requal_sys_11", 32'(sys_rst_n), 1);
    end

    // no lock: relock pulses of 4 every 36 cycles starting at 32
    apply_reset(1);
    for (int n = 1; n <= 72; n++) begin
      step(0);
      if (n == 31 || n == 36 || n == 67) chk($sformatf("relock_low_%0d", n), 32'(relock_req), 0);
      if (n == 32 || n == 35 || n == 68) chk($sformatf("relock_high_%0d", n), 32'(relock_req), 1);
    end

    // five losses: counter saturates at 3
    apply_reset(1);
    for (int k = 1; k <= 5; k++) begin
      repeat (18) step(1);
      repeat (4) step(0);
      chk($sformatf("loss_cnt_%0d", k), 32'(lock_loss_cnt), (k > 3) ? 3 : k);
    end

    // reset asserted mid-STAGE clears everything at once
    for (int n = 0; n < 20 && m_ph != 2; n++) step(1);
    chk("mid_stage", 32'(state_o), 2);
    apply_reset(1);

    // random lock patterns with occasional resets
    repeat (40) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      repeat (len) step(lvl);
      if ($urandom_range(0, 15) == 0) apply_reset(1);
    end

    @(negedge clk_100MHz);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
